// File: rtl/axi_pkg.sv
// Shared AXI response codes, master FSM state encoding and the response-merge helper.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    // A response whose ID or framing does not match the outstanding request is reported as SLVERR.
    function automatic logic [1:0] resp_check(input logic [1:0] resp, input logic beat_ok);
        return beat_ok ? resp : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_timeout_cnt.sv
// Response wait counter: counts while enabled and flags expiry on the last allowed cycle.
module axi_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/axi_master.sv
// Single-outstanding, single-beat AXI master that turns one command into one write or read
// transaction and reports completion, slave response or timeout with a one-cycle pulse.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered, each dropped after its own handshake
// WR_RESP | BREADY high, waiting for B or timeout
// RD_REQ  | AR offered until ARREADY
// RD_RESP | RREADY high, waiting for R or timeout
// DONE    | rsp_valid pulse, back to IDLE
module axi_master
    import axi_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [ID_W-1:0]     cmd_id,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [ID_W-1:0]     AWID,
    output logic                WVALID,
    input  logic                WREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    input  logic                BVALID,
    output logic                BREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    output logic                ARVALID,
    input  logic                ARREADY,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [ID_W-1:0]     ARID,
    input  logic                RVALID,
    output logic                RREADY,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [ID_W-1:0]     RID,
    input  logic [1:0]          RRESP,
    input  logic                RLAST
);

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [ID_W-1:0]     id_q;
    logic                in_resp;
    logic                expired;

    assign in_resp = (state == WR_RESP) || (state == RD_RESP);

    // Held in clear outside the response states, so every response wait starts from zero.
    axi_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .clear   (!in_resp),
        .enable  (in_resp),
        .expired (expired)
    );

    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign AWID   = id_q;
    assign ARID   = id_q;
    assign WSTRB  = '1;
    assign WLAST  = 1'b1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= RESP_OKAY;
            rsp_timeout <= 1'b0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            BREADY      <= 1'b0;
            ARVALID     <= 1'b0;
            RREADY      <= 1'b0;
            addr_q      <= '0;
            WDATA       <= '0;
            id_q        <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        addr_q      <= cmd_addr;
                        WDATA       <= cmd_wdata;
                        id_q        <= cmd_id;
                        rsp_rdata   <= '0;
                        rsp_resp    <= RESP_OKAY;
                        rsp_timeout <= 1'b0;
                        if (cmd_wr) begin
                            state   <= WR_REQ;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end else begin
                            state   <= RD_REQ;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    AWVALID <= AWVALID && !AWREADY;
                    WVALID  <= WVALID && !WREADY;
                    if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) begin
                        state  <= WR_RESP;
                        BREADY <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        rsp_resp  <= resp_check(BRESP, BID == id_q);
                        state     <= DONE;
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (expired) begin
                        rsp_resp    <= RESP_DECERR;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                        BREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RVALID) begin
                        rsp_rdata <= RDATA;
                        rsp_resp  <= resp_check(RRESP, (RID == id_q) && RLAST);
                        state     <= DONE;
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (expired) begin
                        rsp_resp    <= RESP_DECERR;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                        RREADY      <= 1'b0;
                        rsp_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_master.md
AXI_MASTER -- requirements
Module: axi_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 64, data width; ID_W, 4, transaction ID width; TIMEOUT, 256, maximum wait cycles for B or R.
REQ-002 Ports SHALL be as follows, in this order (name direction width meaning):
- ACLK in 1 sole clock; all logic on rising edge.
- ARESETn in 1 asynchronous active-low reset.
- cmd_valid in 1 command request.
- cmd_ready out 1 command accepted.
- cmd_wr in 1 1=write, 0=read.
- cmd_addr in ADDR_W target address.
- cmd_wdata in DATA_W write data.
- cmd_id in ID_W transaction ID.
- rsp_valid out 1 one-cycle completion pulse.
- rsp_rdata out DATA_W read data (0 for writes).
- rsp_resp out 2 AXI response code.
- rsp_timeout out 1 completion caused by timeout.
- AWVALID/AWREADY/AWADDR/AWID out/in/out/out 1/1/ADDR_W/ID_W write address channel.
- WVALID/WREADY/WDATA/WSTRB/WLAST out/in/out/out/out 1/1/DATA_W/DATA_W/8/1 write data channel.
- BVALID/BREADY/BID/BRESP in/out/in/in 1/1/ID_W/2 write response channel.
- ARVALID/ARREADY/ARADDR/ARID out/in/out/out 1/1/ADDR_W/ID_W read address channel.
- RVALID/RREADY/RDATA/RID/RRESP/RLAST in/out/in/in/in/in 1/1/DATA_W/ID_W/2/1 read data channel.
REQ-003 The block SHALL issue single-beat transactions only: LEN=0, WSTRB all ones, WLAST=1 whenever WVALID=1.

Function
REQ-004 FSM states SHALL be IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-005 cmd_ready SHALL equal 1 only in IDLE; a command SHALL be captured (addr, wdata, id, wr) on the cycle cmd_valid&&cmd_ready.
REQ-006 IDLE -> WR_REQ if captured cmd_wr=1, else IDLE -> RD_REQ; AWVALID/WVALID or ARVALID SHALL assert on the first cycle of the entered state.
REQ-007 In WR_REQ, AWVALID and WVALID SHALL each drop the cycle after its own handshake, independently; payload SHALL be stable while VALID is high.
REQ-008 WR_REQ -> WR_RESP once both AW and W handshakes are complete, including when both complete in the same cycle.
REQ-009 In WR_RESP, BREADY=1; when BVALID=1, rsp_resp SHALL latch BRESP and the FSM SHALL go to DONE.
REQ-010 In RD_REQ, ARVALID SHALL stay high until ARREADY; next state RD_RESP.
REQ-011 In RD_RESP, RREADY=1; when RVALID=1, rsp_rdata SHALL latch RDATA, rsp_resp SHALL latch RRESP, next state DONE.
REQ-012 A BID/RID differing from the captured ID SHALL force rsp_resp=2'b10 (SLVERR).
REQ-013 A wait counter SHALL clear on entering WR_RESP/RD_RESP and increment each cycle; at count TIMEOUT-1 without VALID, the FSM SHALL go to DONE with rsp_timeout=1, rsp_resp=2'b11.
REQ-014 After a timeout, BREADY/RREADY SHALL be 0 outside WR_RESP/RD_RESP, so a late B or R is not consumed.
REQ-015 DONE SHALL assert rsp_valid for exactly one cycle and then return to IDLE; command-to-command throughput SHALL be at best 4 cycles for writes and reads.
REQ-016 cmd_valid while not in IDLE SHALL be ignored; the holder SHALL keep it asserted.

Reset
REQ-017 On ARESETn=0, the block SHALL asynchronously go to IDLE, and all outputs SHALL be 0: VALIDs, READYs, rsp_*, addresses, data, IDs, wait counter. Exceptions: cmd_ready=1 one cycle after deassertion; WSTRB=8'hFF and WLAST=1 are constant ties.
REQ-018 Reset mid-transaction SHALL abandon it without a rsp_valid pulse.

Structure
REQ-019 Package axi_pkg SHALL hold the RESP constants (OKAY, EXOKAY, SLVERR, DECERR) and the FSM state enum.
REQ-020 The wait counter SHALL be sub-module axi_timeout_cnt (clear, enable, expired output).

Verification
REQ-021 Write, AWREADY and WREADY both high at once: addr 0x1000_0040, data 0xDEAD_BEEF_0123_4567, id 3, BRESP=0 after 2 cycles -> one rsp_valid, rsp_resp=0, rsp_timeout=0.
REQ-022 Write where WREADY comes 3 cycles after AWREADY -> AWVALID drops first, WDATA stays stable, WR_RESP entered only after W.
REQ-023 Read of addr 0x2000_0008, RDATA=0x1122_3344_5566_7788, RID=5 matching -> rsp_rdata equals RDATA, rsp_resp=0.
REQ-024 Read where RID=6 mismatches captured 5 -> rsp_resp=2'b10.
REQ-025 Write with BVALID never asserted, TIMEOUT=16 -> rsp_valid 16 cycles after WR_RESP entry, rsp_timeout=1, rsp_resp=2'b11, BREADY=0 afterward.
REQ-026 ARESETn pulsed low while in RD_RESP -> ARVALID and RREADY go 0 immediately, no rsp_valid, cmd_ready=1 one cycle after release.
